pcap_stream_writer: RTL

- Inverse of the pcap replay source: captures packets arriving on the single-byte packet bus (available/datavalid/data) and re-emits them as a libpcap-format byte stream: one global header, then one record header plus payload per packet.
- Sits at the sink end of network test benches and loopback designs. Its output stream can be dumped to a file or fed straight back into the pcap replay source.
- Synthesizable. A packet buffer is needed because the record length must precede the payload.

---
 rtl/pcap_stream_writer_if.sv | 19 +
 rtl/pcap_stream_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pcap_stream_writer_if.sv
// Bus bundle for pcap_stream_writer: single-byte packet input bus plus the
// registered pcap byte-stream output with downstream pause.
interface pcap_stream_writer_if;
    logic       in_available;
    logic       in_datavalid;
    logic [7:0] in_data;
    logic       in_pause;
    logic       pause;
    logic       out_valid;
    logic [7:0] out_data;

    // Environment side: packet source and stream sink.
    modport master (output in_available, in_datavalid, in_data, pause,
                    input  in_pause, out_valid, out_data);

    // Writer side.
    modport slave  (input  in_available, in_datavalid, in_data, pause,
                    output in_pause, out_valid, out_data);
endinterface

// File: rtl/pcap_stream_writer.sv
// pcap_stream_writer: captures packets from the single-byte packet bus and
// re-emits them as a libpcap byte stream (global header, then record header
// plus payload per packet). Packets are buffered so incl_len can be sent
// ahead of the payload.
// Optional: define PCAP_STREAM_WRITER_TIMESTAMP_EN for real ts_sec/ts_usec
// fields; without it both fields are emitted as zero.
module pcap_stream_writer #(
    parameter int BUF_DEPTH  = 2048,
    parameter int LINKTYPE   = 1,
    parameter int CLK_PER_US = 50
) (
    input  logic                CLOCK,
    input  logic                RESET,
    pcap_stream_writer_if.slave bus,
    output logic [7:0]          pktcount,
    output logic                idle
);
    localparam int          AW      = $clog2(BUF_DEPTH);
    localparam logic [31:0] DEPTH32 = 32'(BUF_DEPTH);
    localparam logic [31:0] LINK32  = 32'(LINKTYPE);

    typedef enum logic [2:0] {GHDR, IDLE, CAPTURE, RHDR, PAYLOAD} state_t;

    state_t      state_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic [7:0]  pktcount_q;
    logic [4:0]  cnt_q;        // header byte index (global or record)
    logic [31:0] orig_len_q;
    logic [31:0] pidx_q;       // next payload byte to load into out_data
    logic [31:0] ts_sec_q;
    logic [31:0] ts_usec_q;
    logic [31:0] now_sec;
    logic [31:0] now_usec;

    logic [7:0]  mem [BUF_DEPTH];
    logic [7:0]  rd_q;

`ifdef PCAP_STREAM_WRITER_TIMESTAMP_EN
    localparam int DW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    logic [DW-1:0] div_q;
    logic [31:0]   now_sec_q;
    logic [31:0]   now_usec_q;

    // Free-running microsecond/second time base.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            div_q      <= '0;
            now_sec_q  <= '0;
            now_usec_q <= '0;
        end else if (32'(div_q) == 32'(CLK_PER_US - 1)) begin
            div_q <= '0;
            if (now_usec_q == 32'd999999) begin
                now_usec_q <= '0;
                now_sec_q  <= now_sec_q + 32'd1;
            end else begin
                now_usec_q <= now_usec_q + 32'd1;
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign now_sec  = now_sec_q;
    assign now_usec = now_usec_q;
`else
    assign now_sec  = '0;
    assign now_usec = '0;
`endif

    logic          adv;       // output register may load a new byte
    logic          in_pkt;
    logic          cap_vld;
    logic          mem_we;
    logic          ld_pay;
    logic [31:0]   cur_len;
    logic [31:0]   nxt_len;
    logic [31:0]   incl_len;
    logic [31:0]   pidx_d;
    logic [AW-1:0] mem_addr;

    // Capture bookkeeping and RAM address; the read address is the next
    // payload index so rd_q is already valid when out_data must advance.
    always_comb begin
        adv      = !out_valid_q || !bus.pause;
        in_pkt   = (state_q == CAPTURE) || (state_q == IDLE && bus.in_available);
        cur_len  = (state_q == CAPTURE) ? orig_len_q : 32'd0;
        cap_vld  = in_pkt && bus.in_datavalid;
        nxt_len  = (cap_vld && cur_len != 32'hFFFF_FFFF) ? cur_len + 32'd1 : cur_len;
        mem_we   = cap_vld && (cur_len < DEPTH32);
        incl_len = (orig_len_q < DEPTH32) ? orig_len_q : DEPTH32;
        ld_pay   = adv && ((state_q == RHDR && cnt_q == 5'd16) ||
                           (state_q == PAYLOAD && pidx_q < incl_len));
        pidx_d   = ld_pay ? pidx_q + 32'd1 : pidx_q;
        mem_addr = mem_we ? cur_len[AW-1:0] : pidx_d[AW-1:0];
    end

    // Single-port packet buffer with registered read.
    always_ff @(posedge CLOCK) begin
        if (mem_we) mem[mem_addr] <= bus.in_data;
        rd_q <= mem[mem_addr];
    end

    function automatic logic [7:0] le_byte(input logic [31:0] w, input logic [1:0] b);
        return w[8*b +: 8];
    endfunction

    function automatic logic [7:0] ghdr_byte(input logic [4:0] i);
        logic [31:0] w;
        case (i[4:2])
            3'd0:    w = 32'hA1B2_C3D4;
            3'd1:    w = 32'h0004_0002;   // version 2.4
            3'd4:    w = DEPTH32;         // snaplen
            3'd5:    w = LINK32;
            default: w = 32'd0;           // thiszone, sigfigs
        endcase
        return le_byte(w, i[1:0]);
    endfunction

    function automatic logic [7:0] rhdr_byte(input logic [3:0] i, input logic [31:0] sec,
                                             input logic [31:0] usec, input logic [31:0] incl,
                                             input logic [31:0] orig);
        logic [31:0] w;
        case (i[3:2])
            2'd0:    w = sec;
            2'd1:    w = usec;
            2'd2:    w = incl;
            default: w = orig;
        endcase
        return le_byte(w, i[1:0]);
    endfunction

    // Main FSM: header generation, capture, record emission.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= GHDR;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            pktcount_q  <= 8'd0;
            cnt_q       <= 5'd0;
            orig_len_q  <= 32'd0;
            pidx_q      <= 32'd0;
            ts_sec_q    <= 32'd0;
            ts_usec_q   <= 32'd0;
        end else begin
            pidx_q <= pidx_d;
            if (cap_vld && cur_len == 32'd0) begin
                ts_sec_q  <= now_sec;
                ts_usec_q <= now_usec;
            end
            case (state_q)
                GHDR: if (adv) begin
                    if (cnt_q < 5'd24) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= ghdr_byte(cnt_q);
                        cnt_q       <= cnt_q + 5'd1;
                    end else begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= 5'd0;
                        state_q     <= IDLE;
                    end
                end
                IDLE: if (bus.in_available) begin
                    orig_len_q <= nxt_len;
                    state_q    <= CAPTURE;
                end
                CAPTURE: begin
                    orig_len_q <= nxt_len;
                    if (!bus.in_available) begin
                        cnt_q   <= 5'd0;
                        pidx_q  <= 32'd0;
                        state_q <= (nxt_len == 32'd0) ? IDLE : RHDR;
                    end
                end
                RHDR: if (adv) begin
                    out_valid_q <= 1'b1;
                    if (cnt_q < 5'd16) begin
                        out_data_q <= rhdr_byte(cnt_q[3:0], ts_sec_q, ts_usec_q, incl_len, orig_len_q);
                        cnt_q      <= cnt_q + 5'd1;
                    end else begin
                        // first payload byte follows the header with no gap
                        out_data_q <= rd_q;
                        state_q    <= PAYLOAD;
                    end
                end
                PAYLOAD: if (adv) begin
                    if (pidx_q < incl_len) begin
                        out_data_q <= rd_q;
                    end else begin
                        out_valid_q <= 1'b0;
                        pktcount_q  <= pktcount_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= GHDR;
            endcase
        end
    end

    assign bus.in_pause  = !(state_q == IDLE || state_q == CAPTURE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign pktcount      = pktcount_q;
    assign idle          = (state_q == IDLE) && !out_valid_q;
endmodule
